// File: rtl/rom_dl_sequencer.sv
// Steers the HPS ROM download into the shared program/vector/sound ROM storage and gives
// CPU fetches the slots the download does not use. Keeps the game core in reset until
// the ROM image has loaded and settled.
module rom_dl_sequencer #(
    parameter int PROG_SIZE = 8192,
    parameter int VEC_SIZE  = 2048,
    parameter int SND_SIZE  = 256,
    parameter int POST_HOLD = 64
) (
    input  logic        clk_25,
    input  logic        RESET_L,
    input  logic        dn_download,
    input  logic        dn_wr,
    input  logic [15:0] dn_addr,
    input  logic [7:0]  dn_data,
    input  logic        cpu_rd,
    input  logic [15:0] cpu_addr,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_valid,
    output logic        cpu_busy,
    output logic [2:0]  mem_sel,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic        core_reset_l,
    output logic        dl_done,
    output logic [15:0] dl_count,
    output logic [7:0]  dl_sum
);

    typedef enum logic [1:0] {S_BOOT, S_LOAD, S_HOLD, S_RUN} t_state;

    localparam logic [16:0] L_VEC_BASE = 17'(PROG_SIZE);
    localparam logic [16:0] L_SND_BASE = 17'(PROG_SIZE + VEC_SIZE);
    localparam logic [16:0] L_END      = 17'(PROG_SIZE + VEC_SIZE + SND_SIZE);

    // Returns {mapped, one-hot region, region-relative address}.
    function automatic logic [19:0] f_decode(input logic [15:0] a);
        logic [16:0] w;
        w = {1'b0, a};
        if (w < L_VEC_BASE)      return {1'b1, 3'b001, a};
        else if (w < L_SND_BASE) return {1'b1, 3'b010, a - L_VEC_BASE[15:0]};
        else if (w < L_END)      return {1'b1, 3'b100, a - L_SND_BASE[15:0]};
        else                     return {1'b0, 3'b000, a};
    endfunction

    t_state      r_state;
    logic [15:0] r_hold_cnt;
    logic        r_wb_vld;
    logic        r_mem_we;
    logic [2:0]  r_mem_sel;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic [1:0]  r_rd_pipe;
    logic [1:0]  r_um_pipe;
    logic        r_core_reset_l;
    logic        r_dl_done;
    logic [15:0] r_dl_count;
    logic [7:0]  r_dl_sum;

    logic [19:0] w_wr_dec;
    logic [19:0] w_rd_dec;
    logic        w_wr_cap;
    logic        w_rd_acc;

    assign w_wr_dec = f_decode(dn_addr);
    assign w_rd_dec = f_decode(cpu_addr);
    assign w_wr_cap = (r_state == S_LOAD) && dn_wr;
    // A read cannot share the bus with a draining or just-captured write, nor overlap an in-flight read.
    assign w_rd_acc = cpu_rd && !r_wb_vld && !w_wr_cap && !r_rd_pipe[0];

    assign cpu_busy     = cpu_rd && !w_rd_acc;
    assign cpu_valid    = r_rd_pipe[1];
    assign cpu_rdata    = r_rd_pipe[1] ? (r_um_pipe[1] ? 8'hFF : mem_rdata) : 8'h00;
    assign mem_we       = r_mem_we;
    assign mem_sel      = r_mem_sel;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign core_reset_l = r_core_reset_l;
    assign dl_done      = r_dl_done;
    assign dl_count     = r_dl_count;
    assign dl_sum       = r_dl_sum;

    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            r_state        <= S_BOOT;
            r_hold_cnt     <= '0;
            r_wb_vld       <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_sel      <= '0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_rd_pipe      <= '0;
            r_um_pipe      <= '0;
            r_core_reset_l <= 1'b0;
            r_dl_done      <= 1'b0;
            r_dl_count     <= '0;
            r_dl_sum       <= '0;
        end else begin
            r_rd_pipe <= {r_rd_pipe[0], w_rd_acc};
            r_um_pipe <= {r_um_pipe[0], w_rd_acc & ~w_rd_dec[19]};
            r_wb_vld  <= w_wr_cap;

            // The output registers double as the write buffer: captured now, drained next cycle.
            if (w_wr_cap) begin
                r_mem_we    <= w_wr_dec[19];
                r_mem_sel   <= w_wr_dec[18:16];
                r_mem_addr  <= w_wr_dec[15:0];
                r_mem_wdata <= dn_data;
            end else begin
                r_mem_we <= 1'b0;
                if (w_rd_acc) begin
                    r_mem_sel  <= w_rd_dec[18:16];
                    r_mem_addr <= w_rd_dec[15:0];
                end
            end

            if (r_mem_we) begin
                r_dl_count <= r_dl_count + 16'd1;
                r_dl_sum   <= r_dl_sum + r_mem_wdata;
            end

            if (dn_download && r_state != S_LOAD) begin
                r_state        <= S_LOAD;
                r_core_reset_l <= 1'b0;
                r_dl_done      <= 1'b0;
                r_dl_count     <= '0;
                r_dl_sum       <= '0;
            end else begin
                case (r_state)
                    S_LOAD: if (!dn_download) begin
                        r_state    <= S_HOLD;
                        r_hold_cnt <= 16'(POST_HOLD - 1);
                    end
                    S_HOLD: if (r_hold_cnt == 16'd0) r_state <= S_RUN;
                            else r_hold_cnt <= r_hold_cnt - 16'd1;
                    S_RUN: begin
                        r_core_reset_l <= 1'b1;
                        r_dl_done      <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Directed bench for rom_dl_sequencer: behavioural ROM model plus a queue of expected CPU read results.
module tb_rom_dl_sequencer;
    localparam int P  = 8192;
    localparam int V  = 2048;
    localparam int S  = 256;
    localparam int PH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        RESET_L, dn_download, dn_wr, cpu_rd;
    logic [15:0] dn_addr, cpu_addr;
    logic [7:0]  dn_data;
    logic [7:0]  cpu_rdata, mem_wdata, mem_rdata, dl_sum;
    logic        cpu_valid, cpu_busy, mem_we, core_reset_l, dl_done;
    logic [2:0]  mem_sel;
    logic [15:0] mem_addr, dl_count;

    rom_dl_sequencer #(.PROG_SIZE(P), .VEC_SIZE(V), .SND_SIZE(S), .POST_HOLD(PH)) dut (
        .clk_25(clk), .RESET_L(RESET_L), .dn_download(dn_download), .dn_wr(dn_wr),
        .dn_addr(dn_addr), .dn_data(dn_data), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr),
        .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid), .cpu_busy(cpu_busy),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .core_reset_l(core_reset_l), .dl_done(dl_done),
        .dl_count(dl_count), .dl_sum(dl_sum)
    );

    // Region storage with 1-cycle synchronous read from the selected region.
    logic [7:0] m_prog [P];
    logic [7:0] m_vec  [V];
    logic [7:0] m_snd  [S];
    logic [7:0] m_q;
    assign mem_rdata = m_q;
    initial begin
        for (int i = 0; i < P; i++) m_prog[i] = 8'h00;
        for (int i = 0; i < V; i++) m_vec[i]  = 8'h00;
        for (int i = 0; i < S; i++) m_snd[i]  = 8'h00;
        m_q = 8'h00;
    end
    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_sel)
                3'b001:  m_prog[mem_addr[12:0]] <= mem_wdata;
                3'b010:  m_vec[mem_addr[10:0]]  <= mem_wdata;
                3'b100:  m_snd[mem_addr[7:0]]   <= mem_wdata;
                default: ;
            endcase
        end
        case (mem_sel)
            3'b001:  m_q <= m_prog[mem_addr[12:0]];
            3'b010:  m_q <= m_vec[mem_addr[10:0]];
            3'b100:  m_q <= m_snd[mem_addr[7:0]];
            default: m_q <= 8'h00;
        endcase
    end

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int exp_cnt  = 0;
    logic [7:0] exp_sum = 8'h00;
    typedef struct { logic [7:0] d; int c; } exp_t;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cpu_valid === 1'b1) begin
            if (sb.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("rd_data", cpu_rdata, e.d);
                chk("rd_cycle", cyc, e.c);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_wr(input logic [15:0] a, input logic [7:0] d, input logic [2:0] esel,
                         input logic [15:0] eaddr, input logic ok);
        dn_wr = 1'b1; dn_addr = a; dn_data = d;
        tick();
        dn_wr = 1'b0;
        @(negedge clk);
        chk("wr_we", mem_we, ok);
        if (ok) begin
            chk("wr_sel", mem_sel, esel);
            chk("wr_addr", mem_addr, eaddr);
            chk("wr_data", mem_wdata, d);
            exp_cnt++;
            exp_sum += d;
        end
        tick(); tick();
    endtask

    task automatic do_rd(input logic [15:0] a, input logic [7:0] d);
        cpu_rd = 1'b1; cpu_addr = a;
        sb.push_back('{d, cyc + 2});
        @(negedge clk);
        chk("rd_busy", cpu_busy, 1'b0);
        tick();
        cpu_rd = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_core_rst"}, core_reset_l, 1'b0);
        chk({tag, "_done"}, dl_done, 1'b0);
        chk({tag, "_count"}, dl_count, 16'd0);
        chk({tag, "_sum"}, dl_sum, 8'd0);
        chk({tag, "_we"}, mem_we, 1'b0);
        chk({tag, "_sel"}, mem_sel, 3'd0);
        chk({tag, "_valid"}, cpu_valid, 1'b0);
        chk({tag, "_busy"}, cpu_busy, 1'b0);
        chk({tag, "_rdata"}, cpu_rdata, 8'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int n;
        RESET_L = 1'b0; dn_download = 1'b0; dn_wr = 1'b0; cpu_rd = 1'b0;
        dn_addr = '0; dn_data = '0; cpu_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        RESET_L = 1'b1;
        tick();

        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (core_reset_l !== 1'b0 || dl_done !== 1'b0 || mem_we !== 1'b0) bad++;
        end
        chk("idle_boot", bad, 0);
        tick();

        // First download: three mapped bytes and one beyond the sound PROM.
        dn_download = 1'b1;
        tick(); tick();
        chk("load_core_rst", core_reset_l, 1'b0);
        do_wr(16'h0000, 8'h01, 3'b001, 16'h0000, 1'b1);
        do_wr(16'h2000, 8'hAA, 3'b010, 16'h0000, 1'b1);
        do_wr(16'h2800, 8'h55, 3'b100, 16'h0000, 1'b1);
        do_wr(16'h3000, 8'h77, 3'b000, 16'h0000, 1'b0);
        chk("dl_count_a", dl_count, 16'd3);
        chk("dl_sum_a", dl_sum, 8'h00);

        dn_download = 1'b0;
        @(posedge clk);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (core_reset_l === 1'b1) break;
        end
        chk("hold_len", n, PH + 1);
        chk("run_done", dl_done, 1'b1);
        tick();

        do_rd(16'h2000, 8'hAA);
        do_rd(16'h4000, 8'hFF);
        do_rd(16'h0000, 8'h01);
        do_rd(16'h2800, 8'h55);

        // Back-to-back reads: the second is deferred while the first is in flight.
        cpu_rd = 1'b1; cpu_addr = 16'h0000;
        sb.push_back('{8'h01, cyc + 2});
        @(negedge clk);
        chk("pend_first_busy", cpu_busy, 1'b0);
        tick();
        @(negedge clk);
        chk("pend_busy", cpu_busy, 1'b1);
        tick();
        cpu_rd = 1'b0;
        tick(); tick(); tick();

        // Second download: read collides with a buffered write drain.
        dn_download = 1'b1;
        tick();
        chk("reload_core_rst", core_reset_l, 1'b0);
        chk("reload_done", dl_done, 1'b0);
        chk("reload_count", dl_count, 16'd0);
        chk("reload_sum", dl_sum, 8'd0);
        exp_cnt = 0; exp_sum = 8'h00;
        tick();
        dn_wr = 1'b1; dn_addr = 16'h0010; dn_data = 8'h3C;
        tick();
        dn_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 16'h0010;
        @(negedge clk);
        chk("arb_busy", cpu_busy, 1'b1);
        chk("arb_we", mem_we, 1'b1);
        chk("arb_sel", mem_sel, 3'b001);
        chk("arb_addr", mem_addr, 16'h0010);
        exp_cnt++; exp_sum += 8'h3C;
        tick();
        sb.push_back('{8'h3C, cyc + 2});
        @(negedge clk);
        chk("arb_retry_busy", cpu_busy, 1'b0);
        tick();
        cpu_rd = 1'b0;
        tick(); tick(); tick();
        chk("arb_count", dl_count, exp_cnt);
        chk("arb_sum", dl_sum, exp_sum);

        // Download re-asserted during the settling period.
        dn_download = 1'b0;
        repeat (10) tick();
        chk("hold_core_rst", core_reset_l, 1'b0);
        dn_download = 1'b1;
        tick();
        chk("rehold_core_rst", core_reset_l, 1'b0);
        chk("rehold_count", dl_count, 16'd0);
        chk("rehold_sum", dl_sum, 8'd0);
        exp_cnt = 0; exp_sum = 8'h00;
        tick();
        do_wr(16'h0001, 8'h11, 3'b001, 16'h0001, 1'b1);
        chk("rehold_count2", dl_count, exp_cnt);
        chk("rehold_sum2", dl_sum, exp_sum);

        // Reset with a byte sitting in the write buffer.
        dn_wr = 1'b1; dn_addr = 16'h0002; dn_data = 8'h99;
        tick();
        dn_wr = 1'b0;
        @(negedge clk);
        chk("rst_buffered_we", mem_we, 1'b1);
        #1 RESET_L = 1'b0;
        dn_download = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk); #1;
        RESET_L = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_we !== 1'b0) bad++;
        end
        chk("midrst_no_we", bad, 0);
        chk("midrst_count", dl_count, 16'd0);
        tick();
        do_rd(16'h0002, 8'h00);
        do_rd(16'h0001, 8'h11);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
